// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and types for the FIFO read-side stage.
package fifo_pkg;

    // Skid buffer depth; also the bound on words buffered plus in flight.
    localparam int SKID_DEPTH = 2;

    // Default data width of RAM read data and the output stream.
    localparam int DEFAULT_DW = 8;

    // Skid-buffer occupancy, 0..SKID_DEPTH.
    typedef logic [1:0] cnt_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry buffer catching RAM read data and presenting it first-word-fall-through.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          valid,
    output cnt_t          cnt
);

    logic [DW-1:0] mem [SKID_DEPTH];
    logic          head;
    logic          tail;

    // Write is unconditional on push: the issue logic upstream guarantees room.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            head   <= 1'b0;
            tail   <= 1'b0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[tail] <= din;
                tail      <= ~tail;
            end
            if (pop)
                head <= ~head;
            cnt <= cnt_t'(cnt + cnt_t'(push) - cnt_t'(pop));
        end
    end

    assign valid = (cnt != '0);
    assign dout  = mem[head];

endmodule

// File: rtl/fifo_rd_stage.sv
// fifo_rd_stage: issues reads to the FIFO controller and streams RAM data out as valid/ready.
// Optional macro FIFO_RD_STAGE_FV_EN compiles in embedded assertions and covers.
module fifo_rd_stage
    import fifo_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_empty,
    output logic          o_rd,
    input  logic [DW-1:0] i_rdata,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    input  logic          i_ready
);

    logic       inflight;
    logic       pop;
    cnt_t       cnt;
    logic [2:0] occ;

    fifo_skid_buf #(.DW(DW)) u_buf (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .push   (inflight),
        .pop    (pop),
        .din    (i_rdata),
        .dout   (o_data),
        .valid  (o_valid),
        .cnt    (cnt)
    );

    assign pop = o_valid && i_ready;

    // Occupancy after this cycle's capture and pop; a read is only safe if it still leaves room.
    always_comb begin
        occ  = 3'({1'b0, cnt}) + 3'(inflight) - 3'(pop);
        o_rd = i_rstn && !i_empty && (occ < 3'(SKID_DEPTH));
    end

    // RAM data for a strobe arrives one cycle later; remember that it is coming.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            inflight <= 1'b0;
        else
            inflight <= o_rd;
    end

`ifdef FIFO_RD_STAGE_FV_EN
    a_rd_not_empty : assert property (@(posedge i_clk) disable iff (!i_rstn) o_rd |-> !i_empty);
    a_cnt_bound    : assert property (@(posedge i_clk) disable iff (!i_rstn) cnt <= cnt_t'(SKID_DEPTH));
    a_stall_hold   : assert property (@(posedge i_clk) disable iff (!i_rstn)
                                      (o_valid && !i_ready) |=> (o_valid && $stable(o_data)));
    c_cnt_full     : cover property (@(posedge i_clk) disable iff (!i_rstn) cnt == cnt_t'(SKID_DEPTH));
    c_pop_run      : cover property (@(posedge i_clk) disable iff (!i_rstn) pop [*4]);
`endif

endmodule

// File: tb/tb_fifo_rd_stage.sv
// tb_fifo_rd_stage: directed and randomized checks of fifo_rd_stage against a queue model.
module tb_fifo_rd_stage;
    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_empty = 1'b0;
    logic          o_rd;
    logic [DW-1:0] i_rdata = '0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    logic [DW-1:0] q[$];
    logic          inflight_m = 1'b0;
    logic [DW-1:0] pend_word = '0;
    logic          seq_mode = 1'b0;
    logic [DW-1:0] seq_val = '0;

    fifo_rd_stage #(.DW(DW)) u_dut (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_empty (i_empty),
        .o_rd    (o_rd),
        .i_rdata (i_rdata),
        .o_valid (o_valid),
        .o_data  (o_data),
        .i_ready (i_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the consumer sees a word this cycle if one is buffered.
    function automatic logic m_pop();
        return (q.size() != 0) && i_ready;
    endfunction

    // Model: read only if buffered plus incoming words, after this cycle's pop, leave a free slot.
    function automatic logic m_rd();
        int held;
        held = q.size() + int'(inflight_m) - int'(m_pop());
        return i_rstn && !i_empty && (held < 2);
    endfunction

    always @(negedge i_rstn) begin
        q.delete();
        inflight_m = 1'b0;
    end

    always @(posedge i_clk) begin
        logic p, r;
        if (i_rstn) begin
            p = m_pop();
            r = m_rd();
            if (p) void'(q.pop_front());
            if (inflight_m) q.push_back(pend_word);
            inflight_m = r;
            if (r) begin
                if (seq_mode) begin
                    pend_word = seq_val;
                    seq_val = seq_val + 1'b1;
                end else begin
                    pend_word = DW'($urandom);
                end
            end
        end
    end

    always @(negedge i_clk) begin
        check("rd", 32'(o_rd), 32'(m_rd()));
        check("valid", 32'(o_valid), 32'(q.size() != 0));
        if (!i_rstn) check("rst_data", 32'(o_data), 32'h0);
        else if (q.size() != 0) check("data", 32'(o_data), 32'(q[0]));
    end

    task automatic step();
        @(posedge i_clk);
        #1;
        i_rdata = inflight_m ? pend_word : DW'($urandom);
    endtask

    initial begin
        logic [DW-1:0] held;
        bit found;
        repeat (3) step();
        #4;
        check("reset_rd", 32'(o_rd), 32'h0);
        check("reset_valid", 32'(o_valid), 32'h0);
        check("reset_data", 32'(o_data), 32'h0);
        step();
        i_rstn = 1'b1;
        #4;
        check("release_rd", 32'(o_rd), 32'h1);
        step();
        i_empty = 1'b1;
        i_ready = 1'b1;
        repeat (5) step();

        // Latency plus empty rising right behind the strobe.
        seq_mode = 1'b1;
        seq_val = 8'hA5;
        i_empty = 1'b0;
        #4;
        check("lat_c0_rd", 32'(o_rd), 32'h1);
        check("lat_c0_valid", 32'(o_valid), 32'h0);
        step();
        i_empty = 1'b1;
        #4;
        check("lat_c1_valid", 32'(o_valid), 32'h0);
        check("lat_c1_rd", 32'(o_rd), 32'h0);
        step();
        #4;
        check("lat_c2_valid", 32'(o_valid), 32'h1);
        check("lat_c2_data", 32'(o_data), 32'hA5);
        step();
        #4;
        check("lat_c3_valid", 32'(o_valid), 32'h0);
        check("lat_c3_rd", 32'(o_rd), 32'h0);

        // Streaming 8'h01..8'h10 with no bubbles after the first.
        step();
        seq_val = 8'h01;
        i_empty = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 6 && !found; t++) begin
            #4;
            if (o_valid) found = 1'b1;
            else step();
        end
        check("stream_start", 32'(found), 32'h1);
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) begin
                step();
                #4;
            end
            check("stream_valid", 32'(o_valid), 32'h1);
            check("stream_data", 32'(o_data), 32'(k));
        end

        // Backpressure for 5 cycles mid-stream.
        step();
        i_ready = 1'b0;
        #4;
        held = o_data;
        check("bp_expect", 32'(held), 32'h11);
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin
                step();
                #4;
                check("bp_cnt", 32'(u_dut.cnt), 32'h2);
            end
            check("bp_valid", 32'(o_valid), 32'h1);
            check("bp_hold", 32'(o_data), 32'(held));
            check("bp_rd", 32'(o_rd), 32'h0);
        end
        step();
        i_ready = 1'b1;
        #4;
        check("bp_release_data", 32'(o_data), 32'h11);
        step();
        #4;
        check("bp_next_data", 32'(o_data), 32'h12);
        step();
        i_empty = 1'b1;
        repeat (6) step();
        seq_mode = 1'b0;

        // Reset with the buffer full.
        i_ready = 1'b0;
        i_empty = 1'b0;
        repeat (4) step();
        #4;
        check("mid_cnt_full", 32'(u_dut.cnt), 32'h2);
        step();
        i_rstn = 1'b0;
        #1;
        check("mid_async_valid", 32'(o_valid), 32'h0);
        check("mid_async_rd", 32'(o_rd), 32'h0);
        step();
        i_rstn = 1'b1;
        #4;
        check("mid_restart_cnt", 32'(u_dut.cnt), 32'h0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            i_rstn = ($urandom_range(0, 199) != 0);
            i_empty = ($urandom_range(0, 3) == 0);
            i_ready = ($urandom_range(0, 3) != 0);
        end
        step();
        i_rstn = 1'b1;
        repeat (3) step();
        #4;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
